alu_rs: RTL

- Reservation station for integer/branch/jump ops, directly upstream of the combinational ALU.
- Accepts dispatched instructions from the decoder/ROB dispatch logic.
- Holds each instruction until both operands are available, snooping the ALU and LSB broadcast buses for missing operands.
- Issues at most one ready instruction per cycle to the ALU through a registered output bundle.

---
 rtl/alu_rs_pkg.sv | 75 +++++++
 rtl/alu_rs_if.sv | 45 ++++
 rtl/rs_priority_sel.sv | 23 ++
 rtl/alu_rs.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared constants, opcodes and entry/issue structs for the ALU reservation station.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package alu_rs_pkg;

    localparam int IDWidth       = 32;
    localparam int ROBWidth      = 4;
    localparam int AddressWidth  = 32;
    localparam int InstTypeWidth = 6;
    localparam int RS_SIZE       = 8;
    localparam int RS_IDX_W      = 3;

    typedef logic [InstTypeWidth-1:0] op_t;

    localparam op_t NOP  = 6'd0;
    localparam op_t ADD  = 6'd1;
    localparam op_t SUB  = 6'd2;
    localparam op_t ADDI = 6'd3;
    localparam op_t BEQ  = 6'd4;
    localparam op_t JAL  = 6'd5;

    typedef struct packed {
        logic                    busy;
        op_t                     opcode;
        logic [IDWidth-1:0]      vj;
        logic [ROBWidth-1:0]     qj;
        logic [IDWidth-1:0]      vk;
        logic [ROBWidth-1:0]     qk;
        logic [IDWidth-1:0]      a;
        logic [AddressWidth-1:0] pc;
        logic [ROBWidth-1:0]     dest;
    } rs_entry_t;

    typedef struct packed {
        op_t                     opcode;
        logic [IDWidth-1:0]      vj;
        logic [IDWidth-1:0]      vk;
        logic [IDWidth-1:0]      a;
        logic [AddressWidth-1:0] pc;
        logic [ROBWidth-1:0]     dest;
    } rs_issue_t;

    typedef struct packed {
        logic [IDWidth-1:0]  v;
        logic [ROBWidth-1:0] q;
    } opnd_t;

    function automatic rs_issue_t idle_issue();
        rs_issue_t r;
        r        = '0;
        r.opcode = NOP;
        return r;
    endfunction

    // A pending operand picks up a broadcast value; the ALU bus wins a tie.
    function automatic opnd_t resolve(input opnd_t o,
                                      input logic [ROBWidth-1:0] alu_h,
                                      input logic [IDWidth-1:0]  alu_res,
                                      input logic [ROBWidth-1:0] lsb_h,
                                      input logic [IDWidth-1:0]  lsb_res);
        opnd_t r;
        r = o;
        if (o.q != '0) begin
            if (o.q == alu_h) begin
                r.v = alu_res;
                r.q = '0;
            end else if (o.q == lsb_h) begin
                r.v = lsb_res;
                r.q = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and ALU issue signals of the reservation station.
// Latency: n/a (wiring only).
// Backpressure: rs_full_out tells the dispatcher to hold off.
interface alu_rs_if import alu_rs_pkg::*; ();

    logic                    dsp_rs_en_in;
    op_t                     dsp_rs_opcode_in;
    logic [IDWidth-1:0]      dsp_rs_vj_in;
    logic [ROBWidth-1:0]     dsp_rs_qj_in;
    logic [IDWidth-1:0]      dsp_rs_vk_in;
    logic [ROBWidth-1:0]     dsp_rs_qk_in;
    logic [IDWidth-1:0]      dsp_rs_a_in;
    logic [AddressWidth-1:0] dsp_rs_pc_in;
    logic [ROBWidth-1:0]     dsp_rs_dest_in;
    logic                    rs_full_out;

    logic [ROBWidth-1:0]     alu_cdb_h_in;
    logic [IDWidth-1:0]      alu_cdb_result_in;
    logic [ROBWidth-1:0]     lsb_cdb_h_in;
    logic [IDWidth-1:0]      lsb_cdb_result_in;

    op_t                     rs_alu_opcode_out;
    logic [IDWidth-1:0]      rs_alu_vj_out;
    logic [IDWidth-1:0]      rs_alu_vk_out;
    logic [IDWidth-1:0]      rs_alu_a_out;
    logic [AddressWidth-1:0] rs_alu_pc_out;
    logic [ROBWidth-1:0]     rs_alu_dest_out;

    modport master (
        output dsp_rs_en_in, dsp_rs_opcode_in, dsp_rs_vj_in, dsp_rs_qj_in,
               dsp_rs_vk_in, dsp_rs_qk_in, dsp_rs_a_in, dsp_rs_pc_in, dsp_rs_dest_in,
               alu_cdb_h_in, alu_cdb_result_in, lsb_cdb_h_in, lsb_cdb_result_in,
        input  rs_full_out, rs_alu_opcode_out, rs_alu_vj_out, rs_alu_vk_out,
               rs_alu_a_out, rs_alu_pc_out, rs_alu_dest_out
    );

    modport slave (
        input  dsp_rs_en_in, dsp_rs_opcode_in, dsp_rs_vj_in, dsp_rs_qj_in,
               dsp_rs_vk_in, dsp_rs_qk_in, dsp_rs_a_in, dsp_rs_pc_in, dsp_rs_dest_in,
               alu_cdb_h_in, alu_cdb_result_in, lsb_cdb_h_in, lsb_cdb_result_in,
        output rs_full_out, rs_alu_opcode_out, rs_alu_vj_out, rs_alu_vk_out,
               rs_alu_a_out, rs_alu_pc_out, rs_alu_dest_out
    );

endinterface

// File: rtl/rs_priority_sel.sv
// Lowest-index set-bit finder over a request vector.
// Latency: combinational.
// Backpressure: none.
module rs_priority_sel import alu_rs_pkg::*; #(
    parameter int N     = RS_SIZE,
    parameter int IDX_W = RS_IDX_W
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until operands arrive, issues one ready op per cycle.
// Latency: ready op dispatched at edge N appears on the registered outputs at edge N+1.
// Backpressure: rs_full_out (all entries busy at cycle start); rdy_in=0 freezes everything.
module alu_rs import alu_rs_pkg::*; (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       rob_rs_rst_in,
    alu_rs_if.slave    bus
);

    rs_entry_t           entry_q [RS_SIZE];
    rs_entry_t           entry_d [RS_SIZE];
    rs_issue_t           out_q;
    rs_issue_t           out_d;
    logic [RS_SIZE-1:0]  busy_vec;
    logic [RS_SIZE-1:0]  ready_vec;
    logic                free_found;
    logic                issue_found;
    logic [RS_IDX_W-1:0] free_idx;
    logic [RS_IDX_W-1:0] issue_idx;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entry_q[i].busy;
            ready_vec[i] = entry_q[i].busy && (entry_q[i].qj == '0) && (entry_q[i].qk == '0);
        end
    end

    rs_priority_sel #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
        .req_i   (~busy_vec),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    rs_priority_sel #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_issue_sel (
        .req_i   (ready_vec),
        .found_o (issue_found),
        .idx_o   (issue_idx)
    );

    assign bus.rs_full_out = &busy_vec;

    // Free/ready vectors come from cycle-start state, so a slot freed by this
    // cycle's issue and an operand captured by this cycle's snoop both take effect next cycle.
    always_comb begin
        opnd_t oj;
        opnd_t ok;
        oj    = '0;
        ok    = '0;
        out_d = out_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            entry_d[i] = entry_q[i];
        end

        if (rdy_in) begin
            if (rob_rs_rst_in) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    entry_d[i] = '0;
                end
                out_d = idle_issue();
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (entry_q[i].busy) begin
                        oj = resolve(opnd_t'{v: entry_q[i].vj, q: entry_q[i].qj},
                                     bus.alu_cdb_h_in, bus.alu_cdb_result_in,
                                     bus.lsb_cdb_h_in, bus.lsb_cdb_result_in);
                        ok = resolve(opnd_t'{v: entry_q[i].vk, q: entry_q[i].qk},
                                     bus.alu_cdb_h_in, bus.alu_cdb_result_in,
                                     bus.lsb_cdb_h_in, bus.lsb_cdb_result_in);
                        entry_d[i].vj = oj.v;
                        entry_d[i].qj = oj.q;
                        entry_d[i].vk = ok.v;
                        entry_d[i].qk = ok.q;
                    end
                end

                if (issue_found) begin
                    out_d.opcode = entry_q[issue_idx].opcode;
                    out_d.vj     = entry_q[issue_idx].vj;
                    out_d.vk     = entry_q[issue_idx].vk;
                    out_d.a      = entry_q[issue_idx].a;
                    out_d.pc     = entry_q[issue_idx].pc;
                    out_d.dest   = entry_q[issue_idx].dest;
                    entry_d[issue_idx].busy = 1'b0;
                end else begin
                    out_d = idle_issue();
                end

                if (bus.dsp_rs_en_in && free_found) begin
                    oj = resolve(opnd_t'{v: bus.dsp_rs_vj_in, q: bus.dsp_rs_qj_in},
                                 bus.alu_cdb_h_in, bus.alu_cdb_result_in,
                                 bus.lsb_cdb_h_in, bus.lsb_cdb_result_in);
                    ok = resolve(opnd_t'{v: bus.dsp_rs_vk_in, q: bus.dsp_rs_qk_in},
                                 bus.alu_cdb_h_in, bus.alu_cdb_result_in,
                                 bus.lsb_cdb_h_in, bus.lsb_cdb_result_in);
                    entry_d[free_idx].busy   = 1'b1;
                    entry_d[free_idx].opcode = bus.dsp_rs_opcode_in;
                    entry_d[free_idx].vj     = oj.v;
                    entry_d[free_idx].qj     = oj.q;
                    entry_d[free_idx].vk     = ok.v;
                    entry_d[free_idx].qk     = ok.q;
                    entry_d[free_idx].a      = bus.dsp_rs_a_in;
                    entry_d[free_idx].pc     = bus.dsp_rs_pc_in;
                    entry_d[free_idx].dest   = bus.dsp_rs_dest_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            out_q <= idle_issue();
        end else begin
            entry_q <= entry_d;
            out_q   <= out_d;
        end
    end

    assign bus.rs_alu_opcode_out = out_q.opcode;
    assign bus.rs_alu_vj_out     = out_q.vj;
    assign bus.rs_alu_vk_out     = out_q.vk;
    assign bus.rs_alu_a_out      = out_q.a;
    assign bus.rs_alu_pc_out     = out_q.pc;
    assign bus.rs_alu_dest_out   = out_q.dest;

endmodule
